// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-address generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_e;

    localparam int INSTR_BYTES_DEF = 4;

    // Only 2- and 4-byte instructions are supported.
    function automatic int ib_log2(input int bytes);
        return (bytes == 2) ? 1 : 2;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target select/add; optional misalign detect under PC_MISALIGN_TRAP_EN.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  pc_src_e           pc_src,
    input  logic [XLEN-1:0]   br_pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   alu_out,
    output logic              redirect,
    output logic [XLEN-1:0]   target
`ifdef PC_MISALIGN_TRAP_EN
    , output logic            misalign
`endif
);

    localparam int SHIFT = ib_log2(INSTR_BYTES);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw      = '0;
        redirect = 1'b0;
        case (pc_src)
            PC_BRANCH: begin
                raw      = br_pc + imm;
                redirect = 1'b1;
            end
            PC_JALR: begin
                raw      = alu_out & ~XLEN'(1);
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target   = raw;
    assign misalign = redirect && ((raw << (XLEN - SHIFT)) != '0);
`else
    // Without trapping, misaligned targets are silently rounded down.
    assign target   = (raw >> SHIFT) << SHIFT;
`endif

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boot/run/halt FSM, valid/ready fetch port, redirect flush.
// Optional misaligned-target trapping enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_out,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            flush,
    output logic            halted,
    output logic            misalign_trap,
    output logic [XLEN-1:0] bad_target
);

    if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_ib
        $error("pc_gen: INSTR_BYTES must be 2 or 4");
    end

    pc_state_e       state, state_nx;
    logic [XLEN-1:0] pc_q, pc_nx;
    logic            flush_q, flush_nx;
    logic            tgt_redirect, redirect;
    logic [XLEN-1:0] target;

`ifdef PC_MISALIGN_TRAP_EN
    logic            tgt_misalign;
    logic            mis_q, mis_nx;
    logic [XLEN-1:0] bad_q, bad_nx;
`endif

    pc_target_calc #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_calc (
        .pc_src   (pc_src_e'(pc_src)),
        .br_pc    (br_pc),
        .imm      (imm),
        .alu_out  (alu_out),
        .redirect (tgt_redirect),
        .target   (target)
`ifdef PC_MISALIGN_TRAP_EN
        , .misalign (tgt_misalign)
`endif
    );

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign pc_out      = pc_q;
    assign flush       = flush_q;
    assign redirect    = trap_valid || tgt_redirect;

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (halt_req && !redirect) state_nx = HALT;
            HALT:    if (resume && !halt_req)   state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    always_comb begin
        pc_nx    = pc_q;
        flush_nx = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis_nx   = 1'b0;
        bad_nx   = bad_q;
`endif
        if (state != BOOT) begin
            if (trap_valid) begin
                pc_nx = TRAP_VECTOR;
            end else if (tgt_redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
                if (tgt_misalign) begin
                    pc_nx  = TRAP_VECTOR;
                    mis_nx = 1'b1;
                    bad_nx = target;
                end else begin
                    pc_nx  = target;
                end
`else
                pc_nx = target;
`endif
            // A halting cycle withdraws the request, so the PC must not advance.
            end else if (pc_src_e'(pc_src) == PC_SEQ && fetch_valid && fetch_ready
                         && !halt_req) begin
                pc_nx = pc_q + XLEN'(INSTR_BYTES);
            end
            flush_nx = fetch_valid && redirect;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            flush_q <= flush_nx;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
            bad_q <= '0;
        end else begin
            mis_q <= mis_nx;
            bad_q <= bad_nx;
        end
    end

    assign misalign_trap = mis_q;
    assign bad_target    = bad_q;
`else
    assign misalign_trap = 1'b0;
    assign bad_target    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: accepted fetch addresses and flush events are queued and checked by a monitor.
module tb_pc_gen;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] br_pc = '0, imm = '0, alu_out = '0;
    logic        trap_valid = 1'b0, halt_req = 1'b0, resume = 1'b0, fetch_ready = 1'b1;
    logic        fetch_valid, flush, halted, misalign_trap;
    logic [31:0] pc_out, bad_target;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_fetch[$];
    logic [31:0] exp_flush[$];

    pc_gen dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .br_pc(br_pc), .imm(imm),
        .alu_out(alu_out), .trap_valid(trap_valid), .halt_req(halt_req),
        .resume(resume), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .pc_out(pc_out), .flush(flush), .halted(halted),
        .misalign_trap(misalign_trap), .bad_target(bad_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] src, input logic rdy,
                          input logic [31:0] b, input logic [31:0] i);
        pc_src = src; fetch_ready = rdy; br_pc = b; imm = i;
    endtask

    // Monitor: every accepted request and every flush pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (fetch_valid && fetch_ready) begin
                if (exp_fetch.size() == 0) chk("fetch_unexpected", pc_out, 32'hDEAD_BEEF);
                else chk("fetch_pc", pc_out, exp_fetch.pop_front());
            end
            if (flush) begin
                if (exp_flush.size() == 0) chk("flush_unexpected", pc_out, 32'hDEAD_BEEF);
                else chk("flush_pc", pc_out, exp_flush.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_mis", 32'(misalign_trap), 32'h0);
        chk("rst_bad", bad_target, 32'h0);

        rst = 1'b1;
        chk("boot_valid", 32'(fetch_valid), 32'h0);
        step();
        chk("run_valid", 32'(fetch_valid), 32'h1);

        // Sequential fetch 0,4,8,12 then 0x10
        for (int k = 0; k < 4; k++) begin
            exp_fetch.push_back(32'(k * 4));
            step();
        end
        chk("seq_pc", pc_out, 32'h10);

        // Stall three cycles at 0x10
        set_in(2'b00, 1'b0, '0, '0);
        repeat (3) step();
        chk("stall_pc", pc_out, 32'h10);
        fetch_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_fetch.push_back(32'h10 + 32'(k * 4));
            step();
        end
        chk("post_stall_pc", pc_out, 32'h20);

        // Branch while stalled: 0x18 + 0x40
        set_in(2'b01, 1'b0, 32'h18, 32'h40);
        exp_flush.push_back(32'h58);
        step();
        chk("branch_pc", pc_out, 32'h58);

        // Trap beats JALR; accepted request at 0x58
        set_in(2'b10, 1'b1, '0, '0);
        trap_valid = 1'b1; alu_out = 32'h203;
        exp_fetch.push_back(32'h58);
        exp_flush.push_back(32'h100);
        step();
        chk("trap_pc", pc_out, 32'h100);

        // JALR to 0x103: rounded to 0x100, or trapped to 0x100 with misalign
        trap_valid = 1'b0; alu_out = 32'h103; fetch_ready = 1'b0;
        exp_flush.push_back(32'h100);
        step();
        chk("jalr_pc", pc_out, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
        chk("jalr_mis", 32'(misalign_trap), 32'h1);
        chk("jalr_bad", bad_target, 32'h102);
`else
        chk("jalr_mis", 32'(misalign_trap), 32'h0);
`endif

        set_in(2'b00, 1'b1, '0, '0);
        exp_fetch.push_back(32'h100);
        step();
        // Redirect to 0x30 with handshake completing
        set_in(2'b01, 1'b1, 32'h10, 32'h20);
        exp_fetch.push_back(32'h104);
        exp_flush.push_back(32'h30);
        step();
        chk("br30_pc", pc_out, 32'h30);

        // Halt at 0x30
        set_in(2'b00, 1'b0, '0, '0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_valid", 32'(fetch_valid), 32'h0);
        chk("halt_pc", pc_out, 32'h30);

        // Redirect while halted: no flush expected
        set_in(2'b01, 1'b1, 32'h40, 32'h40);
        step();
        chk("halt_redirect_pc", pc_out, 32'h80);
        chk("halt_redirect_flush", 32'(flush), 32'h0);

        // resume with halt_req stays halted
        set_in(2'b00, 1'b1, '0, '0);
        resume = 1'b1; halt_req = 1'b1;
        step();
        chk("resume_blocked", 32'(halted), 32'h1);
        halt_req = 1'b0;
        step();
        resume = 1'b0;
        chk("resume_halted", 32'(halted), 32'h0);
        exp_fetch.push_back(32'h80);
        step();
        exp_fetch.push_back(32'h84);
        step();

        // Hold with handshake completing
        pc_src = 2'b11;
        exp_fetch.push_back(32'h88);
        step();
        chk("hold_pc", pc_out, 32'h88);
        pc_src = 2'b00;
        exp_fetch.push_back(32'h88);
        step();

        // Wrap-around through 0
        set_in(2'b01, 1'b0, 32'hFFFF_FF00, 32'hF8);
        exp_flush.push_back(32'hFFFF_FFF8);
        step();
        set_in(2'b00, 1'b1, '0, '0);
        exp_fetch.push_back(32'hFFFF_FFF8);
        step();
        exp_fetch.push_back(32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc_out, 32'h0);
        exp_fetch.push_back(32'h0);
        step();

        // Branch target 0x42
        set_in(2'b01, 1'b0, 32'h40, 32'h2);
`ifdef PC_MISALIGN_TRAP_EN
        exp_flush.push_back(32'h100);
        step();
        chk("mis_pc", pc_out, 32'h100);
        chk("mis_pulse", 32'(misalign_trap), 32'h1);
        chk("mis_bad", bad_target, 32'h42);
        set_in(2'b00, 1'b0, '0, '0);
        step();
        chk("mis_pulse_end", 32'(misalign_trap), 32'h0);
        chk("mis_bad_held", bad_target, 32'h42);
`else
        exp_flush.push_back(32'h40);
        step();
        chk("align_pc", pc_out, 32'h40);
        chk("align_bad", bad_target, 32'h0);
        set_in(2'b00, 1'b0, '0, '0);
        step();
`endif

        // Reset kills a pending flush immediately
        set_in(2'b01, 1'b0, 32'h0, 32'h60);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_flush", 32'(flush), 32'h0);
        chk("midrst_pc", pc_out, 32'h0);
        chk("midrst_valid", 32'(fetch_valid), 32'h0);
        set_in(2'b00, 1'b1, '0, '0);
        step();

        chk("fetch_q_empty", 32'(exp_fetch.size()), 32'h0);
        chk("flush_q_empty", 32'(exp_flush.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator, the successor to the simple program counter.
- Sits between the control/execute redirect logic and the instruction-memory request port.
- Adds:
  - configurable width and reset/trap vectors
  - a valid/ready fetch handshake with back-pressure
  - a boot/run/halt state machine
  - redirect flush signalling
  - optional misaligned-target trapping

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap_valid or misaligned target (XLEN bits).
- INSTR_BYTES, 4, sequential increment; must be a power of two, 2 or 4.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- pc_src  input  2  00 sequential, 01 br_pc+imm, 10 JALR (alu_out & ~1), 11 hold.
- br_pc  input  XLEN  PC of the redirecting instruction.
- imm  input  XLEN  branch/JAL offset.
- alu_out  input  XLEN  JALR target.
- trap_valid  input  1  take trap this cycle.
- halt_req  input  1  request fetch halt.
- resume  input  1  leave HALT.
- fetch_ready  input  1  instruction memory accepts request.
- fetch_valid  output  1  request valid.
- pc_out  output  XLEN  fetch address.
- flush  output  1  one-cycle pulse: redirect/trap killed an in-flight request.
- halted  output  1  state == HALT.
- misalign_trap  output  1  pulse, misaligned target (feature only).
- bad_target  output  XLEN  offending target (feature only).

Behaviour:
- Reset (rst=0, async):
  - pc_out=RESET_VECTOR, fetch_valid=0, flush=0, halted=0, misalign_trap=0, bad_target=0.
  - State BOOT.
- FSM BOOT -> RUN: unconditional, one cycle after rst deasserts; the first request appears on the second edge.
- FSM RUN:
  - fetch_valid=1.
  - halt_req=1 and no redirect/trap -> HALT next cycle; the current request is withdrawn and pc_out is held.
- FSM HALT:
  - fetch_valid=0, halted=1.
  - resume=1 -> RUN. If resume and halt_req are both 1, stay in HALT.
- PC update priority, registered, evaluated every cycle in RUN and HALT:
  1. trap_valid -> TRAP_VECTOR
  2. pc_src=01 -> br_pc+imm
  3. pc_src=10 -> {alu_out[XLEN-1:1],1'b0}
  4. pc_src=00 with fetch_valid&fetch_ready -> pc_out+INSTR_BYTES
  5. otherwise hold
- Handshake:
  - While fetch_valid=1 and fetch_ready=0, pc_out stays stable unless priority 1-3 fires.
  - If priority 1-3 fires while fetch_valid=1, flush=1 on the next cycle whether or not the handshake completed.
- Arithmetic is modulo 2^XLEN. Wrap from all-ones-minus-3 to 0 is legal and silent.
- In BOOT, all update inputs are ignored.
- Redirects in HALT update pc_out with flush=0; the new PC is fetched after resume.
- pc_src=11 holds pc_out even when the handshake completes.
- rst asserted mid-operation overrides everything immediately, including a pending flush.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - A priority-2/3 target with target % INSTR_BYTES != 0 is not loaded.
  - Instead pc_out=TRAP_VECTOR, misalign_trap=1 for one cycle, bad_target=target (held until next misalign or reset), flush as for a redirect.
- Undefined:
  - Target low log2(INSTR_BYTES) bits are forced to 0.
  - misalign_trap and bad_target are tied 0.

Decomposition:
- Package pc_pkg holds:
  - pc_src_e enum (PC_SEQ, PC_BRANCH, PC_JALR, PC_HOLD)
  - pc_state_e enum (BOOT, RUN, HALT)
  - localparam helpers for log2(INSTR_BYTES)
- One natural sub-module: pc_target_calc, combinational target select/add plus misalign detect; the FSM and registers stay in pc_gen.

Test Plan:
- Reset release, fetch_ready=1, pc_src=00 -> fetch_valid rises at cycle 2; pc_out 0,4,8,12.
- Stall: fetch_ready=0 for 3 cycles at pc_out=0x10 -> pc_out holds 0x10, then 0x14 on the ready cycle.
- Stalled request at 0x20, pc_src=01, br_pc=0x18, imm=0x40 -> pc_out=0x58, flush=1 for one cycle.
- trap_valid together with pc_src=10 -> pc_out=TRAP_VECTOR; JALR alu_out=0x103 without the macro -> pc_out=0x100.
- halt_req at pc_out=0x30, redirect to 0x80 while halted, then resume -> halted=1, fetch_valid=0; pc_out=0x80 with flush=0; fetch restarts at 0x80.
- PC_MISALIGN_TRAP_EN defined, pc_src=01 target 0x42 -> pc_out=TRAP_VECTOR, misalign_trap pulse, bad_target=0x42; pc_out=0xFFFF_FFFC sequential -> 0.
